// File: rtl/key_pulse_pkg.sv
// Shared types and constants for the pushbutton conditioning logic.
// Pure declarations: no latency, no flow control.
package key_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HOLD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam int unsigned BOARD_CLK_HZ = 50_000_000;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Flop chain that brings an asynchronous level into the clock domain; resets to 1.
// Latency STAGES cycles; no flow control.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/key_pulse.sv
// Turns a raw active-low pushbutton into debounced single-cycle CHG pulses with auto-repeat.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES edges from press to CHG; no flow control.
module key_pulse
    import key_pulse_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_N,
    output logic       CHG,
    output logic       HELD,
    output logic [7:0] PRESS_CNT
);

    // Intervals below 2 would put two CHG pulses on adjacent cycles.
    localparam int DLY = (REPEAT_DELAY == 0) ? 0 : ((REPEAT_DELAY < 2) ? 2 : REPEAT_DELAY);
    localparam int PER = (REPEAT_PERIOD == 0) ? 0 : ((REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD);
    localparam int RPT_MAX = (DLY > PER) ? ((DLY > 1) ? DLY : 1) : ((PER > 1) ? PER : 1);
    localparam int RPT_W = cnt_width(RPT_MAX);
    localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_SAT   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'((DLY == 0) ? 0 : DLY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'((PER == 0) ? 0 : PER - 1);
    localparam logic             DLY_OFF  = (DLY == 0);
    localparam logic             PER_OFF  = (PER == 0);

    logic             key_s;
    state_t           state, state_nxt;
    logic [DB_W-1:0]  db_cnt, db_nxt, db_inc;
    logic [RPT_W-1:0] rpt_cnt, rpt_nxt;
    logic             rpt_phase, phase_nxt;
    logic             rpt_off, rpt_off_nxt;
    logic             chg_nxt, held_nxt;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (CLK),
        .rst_n(RST),
        .d    (KEY_N),
        .q    (key_s)
    );

    assign db_inc = (db_cnt == DB_SAT) ? db_cnt : db_cnt + 1'b1;

    always_comb begin
        state_nxt   = state;
        db_nxt      = db_cnt;
        rpt_nxt     = rpt_cnt;
        phase_nxt   = rpt_phase;
        rpt_off_nxt = rpt_off;
        chg_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = PRESS_DB;
                    db_nxt    = '0;
                end
            end
            PRESS_DB: begin
                if (key_s) begin
                    state_nxt = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt   = HOLD;
                    chg_nxt     = 1'b1;
                    rpt_nxt     = '0;
                    phase_nxt   = 1'b0;
                    rpt_off_nxt = DLY_OFF;
                end else begin
                    db_nxt = db_inc;
                end
            end
            HOLD: begin
                if (key_s) begin
                    state_nxt = RELEASE_DB;
                    db_nxt    = '0;
                end else if (!rpt_off) begin
                    // rpt_phase 0 waits out the initial delay, 1 runs the repeat period.
                    if (rpt_cnt == (rpt_phase ? PER_LAST : DLY_LAST)) begin
                        chg_nxt     = 1'b1;
                        rpt_nxt     = '0;
                        phase_nxt   = 1'b1;
                        rpt_off_nxt = PER_OFF;
                    end else begin
                        rpt_nxt = rpt_cnt + 1'b1;
                    end
                end
            end
            RELEASE_DB: begin
                if (!key_s) begin
                    state_nxt   = HOLD;
                    rpt_nxt     = '0;
                    phase_nxt   = 1'b0;
                    rpt_off_nxt = DLY_OFF;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    db_nxt = db_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        held_nxt = (state_nxt == HOLD) || (state_nxt == RELEASE_DB);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            db_cnt    <= '0;
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
            rpt_off   <= 1'b0;
            CHG       <= 1'b0;
            HELD      <= 1'b0;
            PRESS_CNT <= 8'd0;
        end else begin
            state     <= state_nxt;
            db_cnt    <= db_nxt;
            rpt_cnt   <= rpt_nxt;
            rpt_phase <= phase_nxt;
            rpt_off   <= rpt_off_nxt;
            CHG       <= chg_nxt;
            HELD      <= held_nxt;
            if (chg_nxt) begin
                PRESS_CNT <= PRESS_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_pulse.sv
// Directed bench for key_pulse with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_key_pulse;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_n = 1'b1;
    logic       chg;
    logic       held;
    logic [7:0] press_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = -1;
    int consec = 0;
    logic chg_q = 1'b0;

    typedef struct {
        logic       rst_before;
        logic       key_n;
        logic       chg;
        logic       held;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[32];

    key_pulse #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .KEY_N    (key_n),
        .CHG      (chg),
        .HELD     (held),
        .PRESS_CNT(press_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chg && chg_q) consec++;
        chg_q = chg;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic k);
        key_n = k;
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        key_n = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        edge_n = -1;
    endtask

    task automatic check_pulses(input string name, input int got[$], input int exp[$]);
        check({name, "_npulse"}, got.size(), exp.size());
        if (got.size() == exp.size()) begin
            foreach (exp[i]) check($sformatf("%s_edge%0d", name, i), got[i], exp[i]);
        end
    endtask

    initial begin
        int pulses[$];
        int exp_q[$];
        int held_drop;
        int np;

        // Clean press: low for edges 0..9, CHG after edge 6, HELD falls after edge 16.
        for (int n = 0; n < 20; n++) begin
            tbl[n].rst_before = (n == 0);
            tbl[n].key_n      = (n < 10) ? 1'b0 : 1'b1;
            tbl[n].chg        = (n == 6);
            tbl[n].held       = (n >= 6) && (n < 16);
            tbl[n].cnt        = (n >= 6) ? 8'd1 : 8'd0;
        end
        // Bounce: low 2, high 1, low 2, then high; nothing may come out.
        for (int n = 0; n < 12; n++) begin
            tbl[20+n].rst_before = (n == 0);
            tbl[20+n].key_n      = !((n < 2) || (n == 3) || (n == 4));
            tbl[20+n].chg        = 1'b0;
            tbl[20+n].held       = 1'b0;
            tbl[20+n].cnt        = 8'd0;
        end

        #2;
        check("rst_chg", chg, 0);
        check("rst_held", held, 0);
        check("rst_cnt", press_cnt, 0);

        for (int i = 0; i < 32; i++) begin
            if (tbl[i].rst_before) do_reset();
            step(tbl[i].key_n);
            check($sformatf("vec%0d_chg", i), chg, tbl[i].chg);
            check($sformatf("vec%0d_held", i), held, tbl[i].held);
            check($sformatf("vec%0d_cnt", i), press_cnt, tbl[i].cnt);
        end

        // Release bounce: high at edges 10,11, back in HOLD at edge 14, repeat at 34.
        do_reset();
        pulses = {};
        held_drop = 0;
        for (int e = 0; e <= 40; e++) begin
            step((e == 10) || (e == 11));
            if (chg) pulses.push_back(edge_n);
            if (e >= 6 && !held) held_drop++;
        end
        exp_q = '{6, 34};
        check_pulses("relbounce", pulses, exp_q);
        check("relbounce_held_drop", held_drop, 0);

        // Hold 60 cycles: initial pulse then 20 then every 8 until release.
        do_reset();
        pulses = {};
        for (int e = 0; e < 80; e++) begin
            step(e >= 60);
            if (chg) pulses.push_back(edge_n);
        end
        exp_q = '{6, 26, 34, 42, 50, 58};
        check_pulses("hold60", pulses, exp_q);
        check("hold60_cnt", press_cnt, 6);
        check("hold60_held_end", held, 0);

        // Reset while debouncing a second press (db_cnt = 2 after edge 4).
        do_reset();
        for (int e = 0; e < 20; e++) step(e >= 10);
        check("midrst_pre_cnt", press_cnt, 1);
        edge_n = -1;
        for (int e = 0; e < 5; e++) step(1'b0);
        rst = 1'b0;
        #1;
        check("midrst_chg", chg, 0);
        check("midrst_held", held, 0);
        check("midrst_cnt", press_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        edge_n = -1;
        pulses = {};
        for (int e = 0; e < 10; e++) begin
            step(1'b0);
            if (chg) pulses.push_back(edge_n);
        end
        exp_q = '{6};
        check_pulses("midrst", pulses, exp_q);
        check("midrst_post_cnt", press_cnt, 1);

        // Wrap: 256 clean presses, one pulse each, counter back to 0.
        do_reset();
        for (int p = 0; p < 256; p++) begin
            np = 0;
            for (int e = 0; e < 16; e++) begin
                step(e >= 8);
                if (chg) np++;
            end
            check($sformatf("wrap_press%0d_pulses", p), np, 1);
            if (p == 254) check("wrap_cnt_255", press_cnt, 255);
        end
        check("wrap_cnt_0", press_cnt, 0);

        check("no_back_to_back", consec, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
